// File: rtl/boot_load_ctrl_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and word geometry.
package boot_load_ctrl_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = 2;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WRITE = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   // Little-endian pack: the three buffered lanes sit below the byte arriving now.
   function automatic logic [31:0] pack_word(input logic [23:0] lower, input logic [7:0] top);
      return {top, lower};
   endfunction

endpackage

// File: rtl/boot_load_ctrl_if.sv
// UART RX byte handshake and imem write port of the boot loader.
interface boot_load_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/boot_load_ctrl_word_assembler.sv
// Collects received bytes into 32-bit little-endian words; flags the byte that completes a word.
module boot_load_ctrl_word_assembler
   import boot_load_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_i,
   output logic [BYTE_CNT_W-1:0] byte_cnt_o,
   output logic                  word_full_o,
   output logic [31:0]           word_o
);

   localparam logic [BYTE_CNT_W-1:0] LAST_LANE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

   logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
   logic [23:0]           lanes_q, lanes_d;

   // The completing byte is never stored; it is merged straight into word_o.
   assign word_full_o = byte_valid_i & (cnt_q == LAST_LANE);
   assign word_o      = pack_word(lanes_q, byte_i);
   assign byte_cnt_o  = cnt_q;

   always_comb begin
      cnt_d   = cnt_q;
      lanes_d = lanes_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (byte_valid_i) begin
         case (cnt_q)
            2'd0:    lanes_d[7:0]   = byte_i;
            2'd1:    lanes_d[15:8]  = byte_i;
            2'd2:    lanes_d[23:16] = byte_i;
            default: lanes_d        = lanes_q;
         endcase
         cnt_d = cnt_q + BYTE_CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         lanes_q <= 24'h00_0000;
      end else begin
         cnt_q   <= cnt_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: rtl/boot_load_ctrl.sv
// CPU bring-up sequencer: loads NUM_WORDS instruction words from the UART stream into imem,
// holding the core stalled until the program is complete.
module boot_load_ctrl
   import boot_load_ctrl_pkg::*;
#(
   parameter int NUM_WORDS   = 16,
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reload_req_i,
   boot_load_ctrl_if.master  bus,
   output logic              cpu_stall_o,
   output logic              load_done_o,
   output logic [ADDR_W:0]   words_loaded_o,
   output logic              err_timeout_o
);

   localparam int                IDLE_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
   localparam bit                TIMEOUT_EN = (TIMEOUT_CYC != 0);
   localparam logic [ADDR_W:0]   WORDS_FULL = (ADDR_W + 1)'(NUM_WORDS);

   state_e                state_q, state_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [ADDR_W:0]       words_q, words_d;
   logic                  stall_q, stall_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [IDLE_W-1:0]     idle_q, idle_d;

   logic                  accept_s;
   logic                  asm_clear_s;
   logic                  word_full_s;
   logic [31:0]           word_s;
   logic [BYTE_CNT_W-1:0] byte_cnt_s;
   logic [ADDR_W:0]       words_inc_s;

   // RUN keeps accepting so uart_rx never backs up; only LOAD bytes reach the assembler.
   assign bus.rx_ready = (state_q == ST_LOAD) | (state_q == ST_RUN);
   assign accept_s     = bus.rx_valid & (state_q == ST_LOAD) & ~reload_req_i;
   assign words_inc_s  = words_q + (ADDR_W + 1)'(1);

   boot_load_ctrl_word_assembler u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (asm_clear_s),
      .byte_valid_i (accept_s),
      .byte_i       (bus.rx_data),
      .byte_cnt_o   (byte_cnt_s),
      .word_full_o  (word_full_s),
      .word_o       (word_s)
   );

   always_comb begin
      state_d     = state_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      words_d     = words_q;
      stall_d     = stall_q;
      done_d      = done_q;
      err_d       = err_q;
      idle_d      = idle_q;
      asm_clear_s = 1'b0;
      if (reload_req_i) begin
         state_d     = ST_LOAD;
         words_d     = '0;
         stall_d     = 1'b1;
         done_d      = 1'b0;
         err_d       = 1'b0;
         idle_d      = '0;
         asm_clear_s = 1'b1;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (accept_s) begin
                  idle_d = '0;
                  if (word_full_s) begin
                     state_d = ST_WRITE;
                     we_d    = 1'b1;
                     waddr_d = words_q[ADDR_W-1:0];
                     wdata_d = word_s;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end else if (TIMEOUT_EN && (byte_cnt_s != '0)) begin
                  // Stalled mid-word: give up on the partial word, keep what is already in imem.
                  if (idle_q == IDLE_LAST) begin
                     idle_d      = '0;
                     asm_clear_s = 1'b1;
                     err_d       = 1'b1;
                  end else begin
                     idle_d = idle_q + IDLE_W'(1);
                  end
               end else begin
                  idle_d = '0;
               end
            end
            ST_WRITE: begin
               words_d = words_inc_s;
               if (words_inc_s == WORDS_FULL) begin
                  state_d = ST_RUN;
                  stall_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_LOAD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= 32'h0000_0000;
         words_q <= '0;
         stall_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         words_q <= words_d;
         stall_q <= stall_d;
         done_q  <= done_d;
         err_q   <= err_d;
         idle_q  <= idle_d;
      end
   end

   assign bus.imem_we    = we_q;
   assign bus.imem_waddr = waddr_q;
   assign bus.imem_wdata = wdata_q;
   assign cpu_stall_o    = stall_q;
   assign load_done_o    = done_q;
   assign words_loaded_o = words_q;
   assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl: vector table, corner-case sequences and a randomized
// byte stream checked against a word-level reference model.
module tb_boot_load_ctrl;

   localparam int NUM_WORDS   = 2;
   localparam int ADDR_W      = 8;
   localparam int TIMEOUT_CYC = 16;

   logic             clk;
   logic             rst_n;
   logic             reload_req;
   logic             cpu_stall;
   logic             load_done;
   logic [ADDR_W:0]  words_loaded;
   logic             err_timeout;

   int n_cmp  = 0;
   int n_fail = 0;

   boot_load_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

   boot_load_ctrl #(
      .NUM_WORDS   (NUM_WORDS),
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .reload_req_i   (reload_req),
      .bus            (bif),
      .cpu_stall_o    (cpu_stall),
      .load_done_o    (load_done),
      .words_loaded_o (words_loaded),
      .err_timeout_o  (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every imem write as {addr, data}, captured mid-cycle.
   logic [39:0] wr_q[$];
   always @(negedge clk) begin
      if (bif.imem_we === 1'b1) wr_q.push_back({bif.imem_waddr, bif.imem_wdata});
   end

   typedef struct {
      bit          reload_first;
      logic [7:0]  b0, b1, b2, b3;
      logic [7:0]  exp_addr;
      logic [31:0] exp_data;
      logic [8:0]  exp_words;
      logic        exp_done;
   } vec_t;

   vec_t vt [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w = 0;
      while (bif.rx_ready !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      if (bif.rx_ready !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rx_ready_wait: got %0b, expected 1", bif.rx_ready);
      end
      bif.rx_valid = 1'b1;
      bif.rx_data  = b;
      tick();
      bif.rx_valid = 1'b0;
   endtask

   task automatic pulse_reload();
      reload_req = 1'b1;
      tick();
      reload_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  b;
      logic [7:0]  pend[$];
      logic [39:0] exp_q[$];
      int          m_words;
      logic        m_err;
      int          gap;
      int          guard;

      vt[0] = '{1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 8'd0, 32'h0000_0004, 9'd1, 1'b0};
      vt[1] = '{1'b0, 8'h93, 8'h01, 8'h31, 8'h00, 8'd1, 32'h0031_0193, 9'd2, 1'b1};
      vt[2] = '{1'b1, 8'h78, 8'h56, 8'h34, 8'h12, 8'd0, 32'h1234_5678, 9'd1, 1'b0};
      vt[3] = '{1'b0, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'd1, 32'hDEAD_BEEF, 9'd2, 1'b1};

      rst_n        = 1'b0;
      reload_req   = 1'b0;
      bif.rx_valid = 1'b0;
      bif.rx_data  = 8'h00;
      tick();
      tick();
      chk("rst_imem_we",   bif.imem_we,    0);
      chk("rst_waddr",     bif.imem_waddr, 0);
      chk("rst_wdata",     bif.imem_wdata, 0);
      chk("rst_stall",     cpu_stall,      1);
      chk("rst_done",      load_done,      0);
      chk("rst_words",     words_loaded,   0);
      chk("rst_err",       err_timeout,    0);
      chk("rst_rx_ready",  bif.rx_ready,   1);
      rst_n = 1'b1;
      tick();

      // Table: whole words, optional reload before each.
      for (int i = 0; i < 4; i++) begin
         if (vt[i].reload_first) begin
            pulse_reload();
            chk("reload_stall", cpu_stall,    1);
            chk("reload_done",  load_done,    0);
            chk("reload_words", words_loaded, 0);
         end
         send_byte(vt[i].b0);
         send_byte(vt[i].b1);
         send_byte(vt[i].b2);
         send_byte(vt[i].b3);
         chk("vec_we",         bif.imem_we,    1);
         chk("vec_waddr",      bif.imem_waddr, vt[i].exp_addr);
         chk("vec_wdata",      bif.imem_wdata, vt[i].exp_data);
         chk("vec_ready_wr",   bif.rx_ready,   0);
         chk("vec_stall_wr",   cpu_stall,      1);
         tick();
         chk("vec_we_pulse",   bif.imem_we,    0);
         chk("vec_words",      words_loaded,   vt[i].exp_words);
         chk("vec_done",       load_done,      vt[i].exp_done);
         chk("vec_stall",      cpu_stall,      !vt[i].exp_done);
      end

      // RUN: bytes are accepted and discarded.
      chk("run_ready", bif.rx_ready, 1);
      send_byte(8'hAA);
      chk("run_no_we", bif.imem_we, 0);
      tick();
      chk("run_no_we2", bif.imem_we,   0);
      chk("run_done",   load_done,     1);
      chk("run_words",  words_loaded,  2);

      // Reload beats a same-cycle 4th byte; next word starts from lane 0.
      pulse_reload();
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      bif.rx_valid = 1'b1;
      bif.rx_data  = 8'h04;
      reload_req   = 1'b1;
      tick();
      bif.rx_valid = 1'b0;
      reload_req   = 1'b0;
      chk("prio_no_we",  bif.imem_we,  0);
      chk("prio_words",  words_loaded, 0);
      tick();
      chk("prio_no_we2", bif.imem_we,  0);
      send_byte(8'hA1);
      send_byte(8'hB2);
      send_byte(8'hC3);
      send_byte(8'hD4);
      chk("prio_we",    bif.imem_we,    1);
      chk("prio_waddr", bif.imem_waddr, 0);
      chk("prio_wdata", bif.imem_wdata, 32'hD4C3_B2A1);

      // Timeout boundary: 15 idle cycles survive, the 16th drops the partial word.
      do_reset();
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (15) tick();
      chk("to_err_early", err_timeout, 0);
      tick();
      chk("to_err",       err_timeout,  1);
      chk("to_words",     words_loaded, 0);
      chk("to_no_we",     bif.imem_we,  0);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      chk("to_we",    bif.imem_we,    1);
      chk("to_waddr", bif.imem_waddr, 0);
      chk("to_wdata", bif.imem_wdata, 32'h0000_0004);
      tick();
      chk("to_words1", words_loaded, 1);
      chk("to_sticky", err_timeout,  1);

      // Asynchronous reset mid-word, between clock edges.
      send_byte(8'hAB);
      send_byte(8'hCD);
      send_byte(8'hEF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_wdata", bif.imem_wdata, 0);
      chk("arst_words", words_loaded,   0);
      chk("arst_err",   err_timeout,    0);
      chk("arst_stall", cpu_stall,      1);
      chk("arst_done",  load_done,      0);
      #3;
      rst_n = 1'b1;
      tick();
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      chk("arst_waddr2", bif.imem_waddr, 0);
      chk("arst_wdata2", bif.imem_wdata, 32'h1234_5678);

      // Randomized streams with occasional mid-word stalls, checked against a word-level model.
      for (int r = 0; r < 8; r++) begin
         tick();
         tick();
         pulse_reload();
         wr_q.delete();
         exp_q.delete();
         pend.delete();
         m_words = 0;
         m_err   = 1'b0;
         guard   = 0;
         while (m_words < NUM_WORDS && guard < 200) begin
            guard++;
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) gap = $urandom_range(TIMEOUT_CYC, TIMEOUT_CYC + 8);
            else gap = $urandom_range(0, TIMEOUT_CYC - 4);
            repeat (gap) tick();
            if (gap >= TIMEOUT_CYC && pend.size() != 0) begin
               pend.delete();
               m_err = 1'b1;
            end
            send_byte(b);
            pend.push_back(b);
            if (pend.size() == 4) begin
               exp_q.push_back({8'(m_words), pend[3], pend[2], pend[1], pend[0]});
               m_words++;
               pend.delete();
            end
         end
         tick();
         tick();
         send_byte(8'($urandom_range(0, 255)));
         send_byte(8'($urandom_range(0, 255)));
         tick();
         chk("rnd_nwrites", 40'(wr_q.size()), 40'(exp_q.size()));
         for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            chk("rnd_write", wr_q[k], exp_q[k]);
         end
         chk("rnd_done",  load_done,    1);
         chk("rnd_stall", cpu_stall,    0);
         chk("rnd_words", words_loaded, NUM_WORDS);
         chk("rnd_err",   err_timeout,  m_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
